// File: rtl/uart_receive_pkg.sv
// Shared types and line-level constants for the UART receiver.
package uart_receive_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_t;

   localparam logic FRAME_START = 1'b0;
   localparam logic FRAME_STOP  = 1'b1;
   localparam logic LINE_IDLE   = 1'b1;

endpackage

// File: rtl/uart_receive_if.sv
// Word delivery channel of the UART receiver: data plus valid/ready handshake.
interface uart_receive_if #(
   parameter int unsigned D_WIDTH = 9
);
   logic [D_WIDTH-1:0] rx_data;
   logic               rx_valid;
   logic               rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_receive_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_receive_sync
   import uart_receive_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= LINE_IDLE;
         q    <= LINE_IDLE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receive.sv
// UART receiver: start validation, mid-bit sampling, framing/overrun detection and
// a one-entry holding register behind a valid/ready handshake.
module uart_receive
   import uart_receive_pkg::*;
#(
   parameter int unsigned D_WIDTH      = 9,
   parameter int unsigned CLKS_PER_BIT = 1
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           rx,
   uart_receive_if.master rx_bus,
   output logic           rx_busy,
   output logic           frame_err,
   output logic           overrun_err
);

   localparam int unsigned HALF    = (CLKS_PER_BIT - 1) / 2;
   localparam int unsigned T_WIDTH = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned N_WIDTH = $clog2(D_WIDTH + 1);

   localparam logic [T_WIDTH-1:0] TMR_LAST = T_WIDTH'(CLKS_PER_BIT - 1);
   localparam logic [T_WIDTH-1:0] TMR_HALF = T_WIDTH'(HALF);
   localparam logic [T_WIDTH-1:0] TMR_ONE  = T_WIDTH'(1);
   localparam logic [N_WIDTH-1:0] IDX_LAST = N_WIDTH'(D_WIDTH - 1);
   localparam logic [N_WIDTH-1:0] IDX_ONE  = N_WIDTH'(1);

   rx_state_t          state, state_nxt;
   logic [T_WIDTH-1:0] tmr, tmr_nxt;
   logic [N_WIDTH-1:0] idx, idx_nxt;
   logic [D_WIDTH-1:0] shreg, shreg_nxt;
   logic               rx_s;

   logic               stop_sample_c;
   logic               good_stop_c;
   logic               frame_err_c;
   logic               busy_nxt_c;

   logic [D_WIDTH-1:0] data_q;
   logic               valid_q;

   uart_receive_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // State register with bit timer, bit index and shift register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         tmr   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
         idx   <= idx_nxt;
         shreg <= shreg_nxt;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      unique case (state)
         IDLE: begin
            if (rx_s == FRAME_START) begin
               idx_nxt = '0;
               if (HALF == 0) begin
                  state_nxt = DATA;
                  tmr_nxt   = '0;
               end else begin
                  // The detection edge counts as the first cycle of the start bit
                  state_nxt = START;
                  tmr_nxt   = TMR_ONE;
               end
            end
         end
         START: begin
            if (tmr == TMR_HALF) begin
               tmr_nxt   = '0;
               state_nxt = (rx_s == FRAME_START) ? DATA : IDLE;
            end else begin
               tmr_nxt = tmr + TMR_ONE;
            end
         end
         DATA: begin
            if (tmr == TMR_LAST) begin
               tmr_nxt   = '0;
               idx_nxt   = idx + IDX_ONE;
               shreg_nxt = D_WIDTH'({rx_s, shreg} >> 1);
               if (idx == IDX_LAST) begin
                  state_nxt = STOP;
               end
            end else begin
               tmr_nxt = tmr + TMR_ONE;
            end
         end
         STOP: begin
            if (tmr == TMR_LAST) begin
               tmr_nxt   = '0;
               state_nxt = (rx_s == FRAME_STOP) ? IDLE : WAIT_IDLE;
            end else begin
               tmr_nxt = tmr + TMR_ONE;
            end
         end
         WAIT_IDLE: begin
            if (rx_s == LINE_IDLE) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   // Stop-bit decisions feeding the registered outputs
   always_comb begin
      stop_sample_c = 1'b0;
      good_stop_c   = 1'b0;
      frame_err_c   = 1'b0;
      busy_nxt_c    = (state_nxt != IDLE);
      if (state == STOP && tmr == TMR_LAST) begin
         stop_sample_c = 1'b1;
         good_stop_c   = (rx_s == FRAME_STOP);
         frame_err_c   = (rx_s != FRAME_STOP);
      end
   end

   // Holding register, handshake and status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q      <= '0;
         valid_q     <= 1'b0;
         rx_busy     <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         rx_busy     <= busy_nxt_c;
         frame_err   <= frame_err_c;
         overrun_err <= good_stop_c && valid_q && !rx_bus.rx_ready;
         if (good_stop_c && (!valid_q || rx_bus.rx_ready)) begin
            data_q  <= shreg;
            valid_q <= 1'b1;
         end else if (valid_q && rx_bus.rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_bus.rx_data  = data_q;
   assign rx_bus.rx_valid = valid_q;

endmodule
